eth_frame_fifo_ctrl: RTL and testbench

//  Single-clock frame-aware FIFO controller that drives one external sdp_ram

---
 rtl/eth_frame_fifo_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_eth_frame_fifo_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_frame_fifo_ctrl.sv
// Frame-aware receive FIFO controller driving an external simple dual-port RAM.
// Frames become readable only after a good EOF; bad or overflowing frames are rewound.
module eth_frame_fifo_ctrl #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  sreset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    input  logic                  in_last,
    input  logic                  in_bad,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr,
    output logic [DATA_WIDTH:0]   ram_wr_data,
    output logic                  ram_wr_en,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    output logic                  ram_rd_en,
    input  logic [DATA_WIDTH:0]   ram_rd_data,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  frame_drop,
    output logic [15:0]           drop_count,
    output logic [ADDR_WIDTH:0]   frames_pending
);

    localparam logic [ADDR_WIDTH:0] PTR_DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] PTR_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0] CNT_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_DROP
    } wr_state_t;

    wr_state_t             state, state_nxt;
    logic [ADDR_WIDTH:0]   wr_ptr, wr_ptr_nxt;
    logic [ADDR_WIDTH:0]   commit_ptr, commit_ptr_nxt;
    logic [ADDR_WIDTH:0]   rd_ptr;
    logic                  full;
    logic                  wr_accept;
    logic                  commit;
    logic                  drop;

    logic [DATA_WIDTH-1:0] skid_data0, skid_data1;
    logic                  skid_last0, skid_last1;
    logic [1:0]            skid_cnt;
    logic [1:0]            occ_after;
    logic                  rd_inflight;
    logic                  pop;
    logic                  last_xfer;
    logic                  rd_issue;

    assign full = ((wr_ptr - rd_ptr) == PTR_DEPTH);

    // ---------------- write side ----------------
    always_comb begin
        state_nxt      = state;
        wr_ptr_nxt     = wr_ptr;
        commit_ptr_nxt = commit_ptr;
        wr_accept      = 1'b0;
        commit         = 1'b0;
        drop           = 1'b0;
        if (!sreset && in_valid) begin
            unique case (state)
                S_IDLE, S_WRITE: begin
                    if (in_last && in_bad) begin
                        wr_ptr_nxt = commit_ptr;
                        drop       = 1'b1;
                        state_nxt  = S_IDLE;
                    end else if (full) begin
                        // Overflow: rewind now; a final beat drops immediately
                        wr_ptr_nxt = commit_ptr;
                        if (in_last) begin
                            drop      = 1'b1;
                            state_nxt = S_IDLE;
                        end else begin
                            state_nxt = S_DROP;
                        end
                    end else begin
                        wr_accept  = 1'b1;
                        wr_ptr_nxt = wr_ptr + PTR_ONE;
                        if (in_last) begin
                            commit         = 1'b1;
                            commit_ptr_nxt = wr_ptr + PTR_ONE;
                            state_nxt      = S_IDLE;
                        end else begin
                            state_nxt = S_WRITE;
                        end
                    end
                end
                S_DROP: begin
                    if (in_last) begin
                        drop      = 1'b1;
                        state_nxt = S_IDLE;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (sreset) begin
            state      <= S_IDLE;
            wr_ptr     <= '0;
            commit_ptr <= '0;
        end else begin
            state      <= state_nxt;
            wr_ptr     <= wr_ptr_nxt;
            commit_ptr <= commit_ptr_nxt;
        end
    end

    assign ram_wr_en   = wr_accept;
    assign ram_wr_addr = wr_ptr[ADDR_WIDTH-1:0];
    assign ram_wr_data = {in_last, in_data};

    always_ff @(posedge clk) begin
        if (sreset) begin
            frame_drop <= 1'b0;
            drop_count <= '0;
        end else begin
            frame_drop <= drop;
            if (drop && (drop_count != '1)) begin
                drop_count <= drop_count + 16'd1;
            end
        end
    end

    // ---------------- read side ----------------
    assign pop       = (skid_cnt != 2'd0) && out_ready;
    assign last_xfer = pop && skid_last0;
    // Occupancy counted after this cycle's pop so a draining skid keeps 1 beat/cycle
    assign occ_after = skid_cnt - {1'b0, pop} + {1'b0, rd_inflight};
    assign rd_issue  = !sreset && (rd_ptr != commit_ptr) && (occ_after < 2'd2);

    assign ram_rd_en   = rd_issue;
    assign ram_rd_addr = rd_ptr[ADDR_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (sreset) begin
            rd_ptr      <= '0;
            rd_inflight <= 1'b0;
            skid_cnt    <= 2'd0;
            skid_data0  <= '0;
            skid_data1  <= '0;
            skid_last0  <= 1'b0;
            skid_last1  <= 1'b0;
        end else begin
            rd_inflight <= rd_issue;
            skid_cnt    <= occ_after;
            if (rd_issue) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (pop) begin
                if (skid_cnt == 2'd2) begin
                    skid_data0 <= skid_data1;
                    skid_last0 <= skid_last1;
                    if (rd_inflight) begin
                        skid_data1 <= ram_rd_data[DATA_WIDTH-1:0];
                        skid_last1 <= ram_rd_data[DATA_WIDTH];
                    end
                end else if (rd_inflight) begin
                    skid_data0 <= ram_rd_data[DATA_WIDTH-1:0];
                    skid_last0 <= ram_rd_data[DATA_WIDTH];
                end
            end else if (rd_inflight) begin
                if (skid_cnt == 2'd0) begin
                    skid_data0 <= ram_rd_data[DATA_WIDTH-1:0];
                    skid_last0 <= ram_rd_data[DATA_WIDTH];
                end else begin
                    skid_data1 <= ram_rd_data[DATA_WIDTH-1:0];
                    skid_last1 <= ram_rd_data[DATA_WIDTH];
                end
            end
        end
    end

    assign out_valid = (skid_cnt != 2'd0);
    assign out_data  = skid_data0;
    assign out_last  = skid_last0;

    always_ff @(posedge clk) begin
        if (sreset) begin
            frames_pending <= '0;
        end else begin
            unique case ({commit, last_xfer})
                2'b10:   frames_pending <= frames_pending + CNT_ONE;
                2'b01:   frames_pending <= frames_pending - CNT_ONE;
                default: frames_pending <= frames_pending;
            endcase
        end
    end

endmodule

// File: tb/tb_eth_frame_fifo_ctrl.sv
// Randomised bench for eth_frame_fifo_ctrl with a RAM model and a frame-level scoreboard.
module tb_eth_frame_fifo_ctrl;

    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          sreset = 1'b1;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_last = 1'b0;
    logic          in_bad = 1'b0;
    logic [AW-1:0] ram_wr_addr;
    logic [DW:0]   ram_wr_data;
    logic          ram_wr_en;
    logic [AW-1:0] ram_rd_addr;
    logic          ram_rd_en;
    logic [DW:0]   ram_rd_data = '0;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          frame_drop;
    logic [15:0]   drop_count;
    logic [AW:0]   frames_pending;

    eth_frame_fifo_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .sreset(sreset),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_bad(in_bad),
        .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data), .ram_wr_en(ram_wr_en),
        .ram_rd_addr(ram_rd_addr), .ram_rd_en(ram_rd_en), .ram_rd_data(ram_rd_data),
        .out_data(out_data), .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
        .frame_drop(frame_drop), .drop_count(drop_count), .frames_pending(frames_pending)
    );

    always #5 clk = ~clk;

    // RAM with one-cycle registered read and synchronous read-port reset
    logic [DW:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
        if (sreset) ram_rd_data <= '0;
        else if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];
    end

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic [DW:0] expq[$];
    int          xfer_cyc[$];
    int          drop_pulses = 0;
    int          exp_drops = 0;
    int          exp_committed = 0;
    int          got_frames = 0;
    int          peak = 0;
    int          rmode = 0;
    logic        prev_stall = 1'b0;
    logic [DW:0] prev_word = '0;
    logic [DW:0] mon_w;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // out_ready pattern: 0 always high, 1 toggle, 2 random, 3 held low
    initial forever begin
        @(posedge clk);
        #1;
        case (rmode)
            0:       out_ready = 1'b1;
            1:       out_ready = ~out_ready;
            2:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    always @(negedge clk) begin
        if (sreset) begin
            prev_stall = 1'b0;
        end else begin
            if (frame_drop) drop_pulses++;
            if (int'(frames_pending) > peak) peak = int'(frames_pending);
            if (prev_stall) begin
                check("hold_valid", 64'(out_valid), 64'(1));
                check("hold_word", 64'({out_last, out_data}), 64'(prev_word));
            end
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    check("unexpected_beat", 64'({out_last, out_data}), 64'(0));
                end else begin
                    mon_w = expq.pop_front();
                    check("out_word", 64'({out_last, out_data}), 64'(mon_w));
                end
                xfer_cyc.push_back(cyc);
                if (out_last) got_frames++;
            end
            prev_stall = out_valid && !out_ready;
            prev_word  = {out_last, out_data};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [DW-1:0] d, input logic l, input logic b);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        in_bad   = b;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_bad   = 1'b0;
    endtask

    // A frame is kept iff it is not flagged bad and fits into an empty FIFO
    task automatic send_frame(input int len, input bit bad, input bit gaps);
        logic [DW:0]   frm[$];
        logic [DW-1:0] d;
        logic          l;
        for (int i = 0; i < len; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) tick();
            d = $urandom;
            l = (i == len - 1);
            frm.push_back({l, d});
            beat(d, l, l ? bad : 1'($urandom_range(0, 1)));
        end
        if (bad || len > DEPTH) begin
            exp_drops++;
        end else begin
            foreach (frm[k]) expq.push_back(frm[k]);
            exp_committed++;
        end
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        rmode = 0;
        while ((expq.size() != 0 || out_valid) && n < 1000) begin
            tick();
            n++;
        end
        check({tag, "_left"}, 64'(expq.size()), 64'(0));
        check({tag, "_valid"}, 64'(out_valid), 64'(0));
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [DW-1:0] d;
        // reset, with a beat presented to confirm it is ignored
        in_valid = 1'b1;
        in_last  = 1'b1;
        repeat (3) tick();
        check("rst_wr_en", 64'(ram_wr_en), 64'(0));
        check("rst_rd_en", 64'(ram_rd_en), 64'(0));
        check("rst_valid", 64'(out_valid), 64'(0));
        check("rst_pending", 64'(frames_pending), 64'(0));
        check("rst_dropcnt", 64'(drop_count), 64'(0));
        check("rst_drop", 64'(frame_drop), 64'(0));
        in_valid = 1'b0;
        in_last  = 1'b0;
        sreset   = 1'b0;
        rmode    = 0;
        repeat (3) tick();
        check("idle_valid", 64'(out_valid), 64'(0));

        // 4-beat good frame at full rate
        xfer_cyc.delete();
        send_frame(4, 1'b0, 1'b0);
        check("f4_pending", 64'(frames_pending), 64'(1));
        wait_drain("f4");
        check("f4_count", 64'(xfer_cyc.size()), 64'(4));
        if (xfer_cyc.size() == 4) check("f4_rate", 64'(xfer_cyc[3] - xfer_cyc[0]), 64'(3));
        check("f4_pending_end", 64'(frames_pending), 64'(0));

        // bad frame
        send_frame(3, 1'b1, 1'b0);
        tick();
        check("bad_dropcnt", 64'(drop_count), 64'(exp_drops));
        check("bad_pulses", 64'(drop_pulses), 64'(exp_drops));
        repeat (4) tick();
        check("bad_no_valid", 64'(out_valid), 64'(0));

        // 20-beat oversize frame into an empty FIFO
        for (int i = 0; i < 20; i++) begin
            d        = $urandom;
            in_valid = 1'b1;
            in_data  = d;
            in_last  = (i == 19);
            in_bad   = 1'b0;
            #1;
            if (i == 15) check("ovf_wr_b16", 64'(ram_wr_en), 64'(1));
            if (i == 16) check("ovf_wr_b17", 64'(ram_wr_en), 64'(0));
            tick();
            if (i == 18) check("ovf_no_early_drop", 64'(frame_drop), 64'(0));
            if (i == 19) check("ovf_drop_b20", 64'(frame_drop), 64'(1));
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        exp_drops++;
        tick();
        check("ovf_drop_single", 64'(frame_drop), 64'(0));
        check("ovf_dropcnt", 64'(drop_count), 64'(exp_drops));
        send_frame(2, 1'b0, 1'b0);
        wait_drain("after_ovf");
        // exactly DEPTH fits, DEPTH+1 drops on its final beat
        send_frame(DEPTH, 1'b0, 1'b0);
        wait_drain("exact_fill");
        send_frame(DEPTH + 1, 1'b0, 1'b0);
        tick();
        check("fill17_dropcnt", 64'(drop_count), 64'(exp_drops));
        wait_drain("fill17");

        // 5 frames held back, then drained with toggling ready
        rmode = 3;
        peak  = 0;
        tick();
        for (int f = 0; f < 5; f++) send_frame(3, 1'b0, 1'b0);
        check("five_pending", 64'(frames_pending), 64'(5));
        rmode = 1;
        repeat (40) tick();
        wait_drain("five");
        check("five_peak", 64'(peak), 64'(5));
        check("five_pending_end", 64'(frames_pending), 64'(0));

        // reset mid-frame with a committed frame unread
        rmode = 3;
        tick();
        send_frame(2, 1'b0, 1'b0);
        repeat (3) tick();
        check("pre_rst_valid", 64'(out_valid), 64'(1));
        beat($urandom, 1'b0, 1'b0);
        beat($urandom, 1'b0, 1'b0);
        sreset = 1'b1;
        expq.delete();
        tick();
        check("mid_rst_valid", 64'(out_valid), 64'(0));
        check("mid_rst_pending", 64'(frames_pending), 64'(0));
        check("mid_rst_dropcnt", 64'(drop_count), 64'(0));
        sreset        = 1'b0;
        exp_drops     = 0;
        drop_pulses   = 0;
        exp_committed = 0;
        got_frames    = 0;
        rmode         = 0;
        tick();
        send_frame(3, 1'b0, 1'b0);
        wait_drain("post_rst");

        // 1-beat frame latency, then back-to-back single-beat frames
        send_frame(1, 1'b0, 1'b0);
        check("lat_e0", 64'(out_valid), 64'(0));
        tick();
        check("lat_e1", 64'(out_valid), 64'(0));
        tick();
        check("lat_e2_valid", 64'(out_valid), 64'(1));
        check("lat_e2_last", 64'(out_last), 64'(1));
        wait_drain("lat");
        xfer_cyc.delete();
        for (int f = 0; f < 4; f++) send_frame(1, 1'b0, 1'b0);
        wait_drain("b2b");
        check("b2b_count", 64'(xfer_cyc.size()), 64'(4));
        if (xfer_cyc.size() == 4) check("b2b_rate", 64'(xfer_cyc[3] - xfer_cyc[0]), 64'(3));

        // random traffic, kept shallow enough that the FIFO never fills
        rmode = 2;
        for (int f = 0; f < 150; f++) begin
            for (int n = 0; n < 300 && expq.size() > 8; n++) tick();
            if (expq.size() > 8) check("gate_timeout", 64'(expq.size()), 64'(8));
            send_frame($urandom_range(1, 5), ($urandom_range(0, 5) == 0), 1'b1);
        end
        wait_drain("rand");
        check("rand_dropcnt", 64'(drop_count), 64'(exp_drops));
        check("rand_pulses", 64'(drop_pulses), 64'(exp_drops));
        check("rand_frames", 64'(got_frames), 64'(exp_committed));
        check("rand_pending", 64'(frames_pending), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
